// File: rtl/branch_resolve.sv
// Resolve-stage companion to the branch predictor: carries prediction metadata to EX/MEM,
// detects mispredicts and drives redirect/flush. Optional perf counters: BRANCH_RESOLVE_PERF_EN.
module branch_resolve #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [15:0] if_pc,
  input  logic        prediction_made,
  input  logic        branch_prediction,
  input  logic [15:0] branch_prediction_address,
  input  logic [7:0]  branch_history_out,
  input  logic        mem_valid,
  input  logic        mem_is_ctrl,
  input  logic        branched,
  input  logic [15:0] mem_target,
  output logic        pc_redirect,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        mispredict,
  output logic [7:0]  pc_EX_MEM,
  output logic [7:0]  branch_history_EX_MEM
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [15:0] perf_resolved,
  output logic [15:0] perf_mispredicts
`endif
);

  localparam int         RI       = DEPTH - 1;
  localparam logic [2:0] LP_FLUSH = 3'(FLUSH_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_pc_redirect;
  logic [15:0] r_redirect_pc;
  logic        r_flush;
  logic        r_mispredict;

  logic        r_v  [DEPTH];
  logic        r_pt [DEPTH];
  logic [15:0] r_pa [DEPTH];
  logic [15:0] r_pc [DEPTH];
  logic [7:0]  r_h  [DEPTH];

  logic        w_q;
  logic        w_mis;
  logic [15:0] w_target;

  // Entry 0 captures fetch; every entry is invalidated on an unstalled flush cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_v[k]  <= 1'b0;
        r_pt[k] <= 1'b0;
        r_pa[k] <= 16'h0000;
        r_pc[k] <= 16'h0000;
        r_h[k]  <= 8'h00;
      end
    end else if (!stall) begin
      r_v[0]  <= if_valid & ~r_flush;
      r_pt[0] <= prediction_made & branch_prediction;
      r_pa[0] <= branch_prediction_address;
      r_pc[0] <= if_pc;
      r_h[0]  <= branch_history_out;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]  <= r_v[k-1] & ~r_flush;
        r_pt[k] <= r_pt[k-1];
        r_pa[k] <= r_pa[k-1];
        r_pc[k] <= r_pc[k-1];
        r_h[k]  <= r_h[k-1];
      end
    end
  end

  assign w_q = ~stall & mem_valid & mem_is_ctrl & r_v[RI] & (r_state == S_IDLE);

  // Predicted-taken but fell through restarts at the sequential PC.
  always_comb begin
    w_mis    = 1'b0;
    w_target = mem_target;
    if (w_q) begin
      if (r_pt[RI] & ~branched) begin
        w_mis    = 1'b1;
        w_target = r_pc[RI] + 16'd2;
      end else if (~r_pt[RI] & branched) begin
        w_mis = 1'b1;
      end else if (r_pt[RI] & branched & (r_pa[RI] != mem_target)) begin
        w_mis = 1'b1;
      end
    end
  end

  // Strobes always drop after one cycle; only the flush countdown respects stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_pc_redirect <= 1'b0;
      r_redirect_pc <= 16'h0000;
      r_flush       <= 1'b0;
      r_mispredict  <= 1'b0;
    end else begin
      r_pc_redirect <= 1'b0;
      r_mispredict  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mis) begin
            r_state       <= S_FLUSH;
            r_cnt         <= LP_FLUSH;
            r_pc_redirect <= 1'b1;
            r_mispredict  <= 1'b1;
            r_redirect_pc <= w_target;
            r_flush       <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (!stall) begin
            if (r_cnt == 3'd1) begin
              r_state <= S_IDLE;
              r_cnt   <= 3'd0;
              r_flush <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc_redirect           = r_pc_redirect;
  assign redirect_pc           = r_redirect_pc;
  assign flush                 = r_flush;
  assign mispredict            = r_mispredict;
  assign pc_EX_MEM             = r_pc[RI][7:0];
  assign branch_history_EX_MEM = r_h[RI];

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [15:0] r_perf_resolved;
  logic [15:0] r_perf_mispredicts;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_resolved    <= 16'h0000;
      r_perf_mispredicts <= 16'h0000;
    end else begin
      if (w_q && (r_perf_resolved != 16'hFFFF))
        r_perf_resolved <= r_perf_resolved + 16'd1;
      if (w_mis && (r_perf_mispredicts != 16'hFFFF))
        r_perf_mispredicts <= r_perf_mispredicts + 16'd1;
    end
  end

  assign perf_resolved    = r_perf_resolved;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-level reference model.
module tb_branch_resolve;

  localparam int DEPTH        = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int RING         = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_pc = 16'h0;
  logic        prediction_made = 1'b0;
  logic        branch_prediction = 1'b0;
  logic [15:0] branch_prediction_address = 16'h0;
  logic [7:0]  branch_history_out = 8'h0;
  logic        mem_valid = 1'b0;
  logic        mem_is_ctrl = 1'b0;
  logic        branched = 1'b0;
  logic [15:0] mem_target = 16'h0;
  logic        pc_redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic        mispredict;
  logic [7:0]  pc_EX_MEM;
  logic [7:0]  branch_history_EX_MEM;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [15:0] perf_resolved;
  logic [15:0] perf_mispredicts;
`endif

  int checks = 0;
  int errors = 0;
  logic cmpEn = 1'b0;

  branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .prediction_made(prediction_made),
    .branch_prediction(branch_prediction),
    .branch_prediction_address(branch_prediction_address),
    .branch_history_out(branch_history_out),
    .mem_valid(mem_valid),
    .mem_is_ctrl(mem_is_ctrl),
    .branched(branched),
    .mem_target(mem_target),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .mispredict(mispredict),
    .pc_EX_MEM(pc_EX_MEM),
    .branch_history_EX_MEM(branch_history_EX_MEM)
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    .perf_resolved(perf_resolved),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each fetched instruction is a record tagged with the advance count at
  // which it entered; the resolve stage sees the record fetched DEPTH-1 advances ago.
  typedef struct {
    logic        v;
    logic        pt;
    logic [15:0] pa;
    logic [15:0] pc;
    logic [7:0]  h;
    int          adv;
  } rec_t;

  rec_t        mRec [RING];
  int          mAdv;
  int          mLastFlush;
  int          mFlushLeft;
  logic        mRedirect;
  logic        mMis;
  logic [15:0] mRedirectPc;
  int          mPerfRes;
  int          mPerfMis;

  task automatic modelReset();
    for (int i = 0; i < RING; i++) begin
      mRec[i].v   = 1'b0;
      mRec[i].pt  = 1'b0;
      mRec[i].pa  = 16'h0;
      mRec[i].pc  = 16'h0;
      mRec[i].h   = 8'h0;
      mRec[i].adv = 0;
    end
    mAdv        = RING;
    mLastFlush  = 0;
    mFlushLeft  = 0;
    mRedirect   = 1'b0;
    mMis        = 1'b0;
    mRedirectPc = 16'h0;
    mPerfRes    = 0;
    mPerfMis    = 0;
  endtask

  task automatic modelStep();
    rec_t        r;
    logic        rValid;
    logic        inFlush;
    logic        decide;
    logic        wrong;
    logic [15:0] tgt;
    int          idx;
    r       = mRec[(mAdv - (DEPTH - 1)) % RING];
    rValid  = r.v && (mLastFlush < r.adv);
    inFlush = (mFlushLeft > 0);
    decide  = !stall && mem_valid && mem_is_ctrl && rValid && !inFlush;
    wrong   = 1'b0;
    tgt     = mem_target;
    if (decide) begin
      if (r.pt != branched) wrong = 1'b1;
      else if (r.pt && (r.pa != mem_target)) wrong = 1'b1;
      if (r.pt && !branched) tgt = r.pc + 16'd2;
    end
    mRedirect = decide && wrong;
    mMis      = decide && wrong;
    if (decide && wrong) begin
      mRedirectPc = tgt;
      mFlushLeft  = FLUSH_CYCLES;
    end else if (inFlush && !stall) begin
      mFlushLeft = mFlushLeft - 1;
    end
    if (decide && mPerfRes < 65535) mPerfRes++;
    if (decide && wrong && mPerfMis < 65535) mPerfMis++;
    if (!stall) begin
      mAdv++;
      if (inFlush) mLastFlush = mAdv;
      idx = mAdv % RING;
      mRec[idx].v   = if_valid && !inFlush;
      mRec[idx].pt  = prediction_made & branch_prediction;
      mRec[idx].pa  = branch_prediction_address;
      mRec[idx].pc  = if_pc;
      mRec[idx].h   = branch_history_out;
      mRec[idx].adv = mAdv;
    end
  endtask

  // Model advances on the same edges as the DUT, from the inputs driven at the prior negedge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (reset_n && cmpEn) begin
      checkOutput("pc_redirect", 32'(pc_redirect), 32'(mRedirect));
      checkOutput("mispredict", 32'(mispredict), 32'(mMis));
      checkOutput("flush", 32'(flush), 32'(mFlushLeft > 0));
      checkOutput("redirect_pc", 32'(redirect_pc), 32'(mRedirectPc));
      checkOutput("pc_EX_MEM", 32'(pc_EX_MEM), 32'(mRec[(mAdv - (DEPTH - 1)) % RING].pc[7:0]));
      checkOutput("history_EX_MEM", 32'(branch_history_EX_MEM), 32'(mRec[(mAdv - (DEPTH - 1)) % RING].h));
`ifdef BRANCH_RESOLVE_PERF_EN
      checkOutput("perf_resolved", 32'(perf_resolved), 32'(mPerfRes));
      checkOutput("perf_mispredicts", 32'(perf_mispredicts), 32'(mPerfMis));
`endif
    end
  end

  task automatic applyStimulus(input logic st, input logic iv, input logic [15:0] ipc,
                               input logic pm, input logic bp, input logic [15:0] pa,
                               input logic [7:0] h, input logic mv, input logic br,
                               input logic [15:0] tgt);
    @(negedge clk);
    stall                     = st;
    if_valid                  = iv;
    if_pc                     = ipc;
    prediction_made           = pm;
    branch_prediction         = bp;
    branch_prediction_address = pa;
    branch_history_out        = h;
    mem_valid                 = mv;
    mem_is_ctrl               = mv;
    branched                  = br;
    mem_target                = tgt;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycle(input logic st);
    applyStimulus(st, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic fetchCycle(input logic [15:0] ipc, input logic pt, input logic [15:0] pa, input logic [7:0] h);
    applyStimulus(1'b0, 1'b1, ipc, pt, pt, pa, h, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic resolveCycle(input logic st, input logic br, input logic [15:0] tgt);
    applyStimulus(st, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, br, tgt);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cmpEn   = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("reset_pc_redirect", 32'(pc_redirect), 32'h0);
    checkOutput("reset_flush", 32'(flush), 32'h0);
    checkOutput("reset_redirect_pc", 32'(redirect_pc), 32'h0);

    // Correct taken prediction
    fetchCycle(16'h0040, 1'b1, 16'h0080, 8'h5A);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("ok_pc_EX_MEM", 32'(pc_EX_MEM), 32'h40);
    checkOutput("ok_history", 32'(branch_history_EX_MEM), 32'h5A);
    resolveCycle(1'b0, 1'b1, 16'h0080);
    checkOutput("ok_pc_redirect", 32'(pc_redirect), 32'h0);
    checkOutput("ok_flush", 32'(flush), 32'h0);
    checkOutput("ok_mispredict", 32'(mispredict), 32'h0);

    // Not-taken mispredict; the younger instruction must be squashed
    fetchCycle(16'h0100, 1'b1, 16'h0180, 8'h11);
    fetchCycle(16'h0102, 1'b0, 16'h0000, 8'h22);
    idleCycle(1'b0);
    resolveCycle(1'b0, 1'b0, 16'h0180);
    checkOutput("nt_pc_redirect", 32'(pc_redirect), 32'h1);
    checkOutput("nt_redirect_pc", 32'(redirect_pc), 32'h0102);
    checkOutput("nt_flush_rise", 32'(flush), 32'h1);
    checkOutput("nt_mispredict", 32'(mispredict), 32'h1);
    resolveCycle(1'b0, 1'b1, 16'h0500);
    checkOutput("nt_squash_redirect", 32'(pc_redirect), 32'h0);
    checkOutput("nt_flush_2nd", 32'(flush), 32'h1);
    idleCycle(1'b0);
    checkOutput("nt_flush_fall", 32'(flush), 32'h0);
    checkOutput("nt_redirect_hold", 32'(redirect_pc), 32'h0102);

    // Wrong target
    fetchCycle(16'h0010, 1'b1, 16'h0200, 8'h33);
    idleCycle(1'b0);
    idleCycle(1'b0);
    resolveCycle(1'b0, 1'b1, 16'h0300);
    checkOutput("wt_redirect_pc", 32'(redirect_pc), 32'h0300);
    checkOutput("wt_pc_redirect", 32'(pc_redirect), 32'h1);
    idleCycle(1'b0);
    idleCycle(1'b0);

    // Sequential PC wrap-around
    fetchCycle(16'hFFFE, 1'b1, 16'h1000, 8'h44);
    idleCycle(1'b0);
    idleCycle(1'b0);
    resolveCycle(1'b0, 1'b0, 16'h1000);
    checkOutput("wrap_redirect_pc", 32'(redirect_pc), 32'h0000);
    checkOutput("wrap_pc_redirect", 32'(pc_redirect), 32'h1);
    idleCycle(1'b0);
    idleCycle(1'b0);

    // Stalled mispredict, then stall inside flush
    fetchCycle(16'h0020, 1'b0, 16'h0000, 8'h55);
    idleCycle(1'b0);
    idleCycle(1'b0);
    for (int i = 0; i < 3; i++) begin
      resolveCycle(1'b1, 1'b1, 16'h0444);
      checkOutput("stall_no_strobe", 32'(pc_redirect), 32'h0);
    end
    resolveCycle(1'b0, 1'b1, 16'h0444);
    checkOutput("stall_strobe", 32'(pc_redirect), 32'h1);
    checkOutput("stall_redirect_pc", 32'(redirect_pc), 32'h0444);
    idleCycle(1'b1);
    checkOutput("stall_strobe_drop", 32'(pc_redirect), 32'h0);
    checkOutput("stall_mis_drop", 32'(mispredict), 32'h0);
    checkOutput("stall_flush_held1", 32'(flush), 32'h1);
    idleCycle(1'b1);
    checkOutput("stall_flush_held2", 32'(flush), 32'h1);
    idleCycle(1'b0);
    checkOutput("stall_flush_held3", 32'(flush), 32'h1);
    idleCycle(1'b0);
    checkOutput("stall_flush_fall", 32'(flush), 32'h0);

    // Reset during flush
    fetchCycle(16'h0300, 1'b1, 16'h0380, 8'h66);
    idleCycle(1'b0);
    idleCycle(1'b0);
    resolveCycle(1'b0, 1'b0, 16'h0380);
    checkOutput("rst_pre_flush", 32'(flush), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_flush", 32'(flush), 32'h0);
    checkOutput("rst_async_redirect", 32'(pc_redirect), 32'h0);
    checkOutput("rst_async_mis", 32'(mispredict), 32'h0);
    checkOutput("rst_async_redirect_pc", 32'(redirect_pc), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idleCycle(1'b0);
    checkOutput("rst_after_redirect", 32'(pc_redirect), 32'h0);
    resolveCycle(1'b0, 1'b1, 16'h1234);
    checkOutput("rst_invalid_entry", 32'(pc_redirect), 32'h0);

    // Three resolves, one mispredict
    fetchCycle(16'h0040, 1'b1, 16'h0080, 8'h01);
    fetchCycle(16'h0042, 1'b0, 16'h0000, 8'h02);
    fetchCycle(16'h0044, 1'b0, 16'h0000, 8'h03);
    resolveCycle(1'b0, 1'b1, 16'h0080);
    resolveCycle(1'b0, 1'b0, 16'h0000);
    resolveCycle(1'b0, 1'b1, 16'h0999);
    checkOutput("perf_seq_redirect_pc", 32'(redirect_pc), 32'h0999);
`ifdef BRANCH_RESOLVE_PERF_EN
    checkOutput("perf_resolved_3", 32'(perf_resolved), 32'd3);
    checkOutput("perf_mispredicts_1", 32'(perf_mispredicts), 32'd1);
`endif
    idleCycle(1'b0);
    idleCycle(1'b0);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] targets [4];
      targets[0] = 16'h0080;
      targets[1] = 16'h0100;
      targets[2] = 16'h0180;
      targets[3] = 16'hFFFE;
      if (i == 1000) begin
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      applyStimulus(($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) < 7),
                    targets[$urandom_range(0, 3)] + 16'($urandom_range(0, 3) * 2),
                    1'($urandom),
                    1'($urandom),
                    targets[$urandom_range(0, 3)],
                    8'($urandom),
                    ($urandom_range(0, 9) < 6),
                    1'($urandom),
                    targets[$urandom_range(0, 3)]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
